ysyx_25040129_ifu: RTL and testbench

Instruction fetch unit for the ysyx_25040129 multi-cycle core. It holds the architectural PC and issues one read per instruction on an AXI4-Lite-style read channel (AR/R) to instruction memory. It presents the fetched word and its PC to the decode stage through a valid/ready handshake. It then waits for write-back to return the next PC before fetching again, so at most one instruction is in flight.

---
 rtl/ysyx_25040129_ifu_pkg.sv | 15 +
 rtl/ysyx_25040129_ifu.sv | 86 ++++++++
 tb/tb_ysyx_25040129_ifu.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_ifu_pkg.sv
// Shared definitions for the ysyx_25040129 instruction fetch unit.
// FSM encoding, AXI response code and the core-wide reset PC.
package ysyx_25040129_ifu_pkg;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_RESP  = 2'd1,
      S_VALID = 2'd2,
      S_WAIT  = 2'd3
   } ifu_state_t;

   localparam logic [1:0]  RESP_OKAY        = 2'b00;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25040129_ifu.sv
// Instruction fetch unit: one AR/R read per instruction, hands the word to decode by valid/ready,
// then waits for write-back's next PC. Outputs are driven from state and registers only.
module ysyx_25040129_ifu
   import ysyx_25040129_ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        inst_fault,
   output logic        is_req_valid_to_idu,
   input  logic        is_req_ready_from_idu,
   input  logic        wb_valid,
   input  logic [31:0] wb_next_pc,
   output logic [31:0] fetch_cnt
);

   ifu_state_t state, state_nxt;
   logic       in_rst;
   logic       pc_misaligned;

   // in_rst is a registered copy of rst, so bus outputs stay low during reset
   // without a combinational path from rst to the ports.
   assign pc_misaligned       = (pc[1:0] != 2'b00);
   assign araddr              = pc;
   assign arvalid             = (state == S_REQ) && !pc_misaligned && !in_rst;
   assign rready              = (state == S_RESP);
   assign is_req_valid_to_idu = (state == S_VALID);

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_REQ: begin
            if (!in_rst) begin
               if (pc_misaligned)         state_nxt = S_VALID;
               else if (arready)          state_nxt = S_RESP;
            end
         end
         S_RESP:  if (rvalid)                state_nxt = S_VALID;
         S_VALID: if (is_req_ready_from_idu) state_nxt = S_WAIT;
         S_WAIT:  if (wb_valid)              state_nxt = S_REQ;
         default:                            state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_REQ;
         in_rst     <= 1'b1;
         pc         <= RESET_PC;
         inst       <= 32'h0;
         inst_fault <= 1'b0;
         fetch_cnt  <= 32'h0;
      end else begin
         state  <= state_nxt;
         in_rst <= 1'b0;
         unique case (state)
            S_REQ: begin
               if (!in_rst && pc_misaligned) begin
                  inst       <= 32'h0;
                  inst_fault <= 1'b1;
               end
            end
            S_RESP: begin
               if (rvalid) begin
                  inst       <= rdata;
                  inst_fault <= (rresp != RESP_OKAY);
               end
            end
            S_VALID: if (is_req_ready_from_idu) fetch_cnt <= fetch_cnt + 32'd1;
            S_WAIT:  if (wb_valid)              pc        <= wb_next_pc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25040129_ifu.sv
// Directed bench for ysyx_25040129_ifu: a vector table of fetches plus reset-in-flight sequences.
module tb_ysyx_25040129_ifu;

   logic        clk;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_fault;
   logic        is_req_valid_to_idu;
   logic        is_req_ready_from_idu;
   logic        wb_valid;
   logic [31:0] wb_next_pc;
   logic [31:0] fetch_cnt;

   int          n_cmp;
   int          n_fail;
   logic [31:0] exp_cnt;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   ysyx_25040129_ifu #(.RESET_PC(RST_PC)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .araddr                (araddr),
      .arvalid               (arvalid),
      .arready               (arready),
      .rdata                 (rdata),
      .rresp                 (rresp),
      .rvalid                (rvalid),
      .rready                (rready),
      .inst                  (inst),
      .pc                    (pc),
      .inst_fault            (inst_fault),
      .is_req_valid_to_idu   (is_req_valid_to_idu),
      .is_req_ready_from_idu (is_req_ready_from_idu),
      .wb_valid              (wb_valid),
      .wb_next_pc            (wb_next_pc),
      .fetch_cnt             (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] exp_pc;
      logic        exp_bus;
      int          ar_stall;
      logic        wb_in_resp;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      int          ack_delay;
      logic [31:0] exp_inst;
      logic        exp_fault;
      logic [31:0] next_pc;
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".arvalid"},    {31'h0, arvalid},             32'h0);
      chk({tag, ".rready"},     {31'h0, rready},              32'h0);
      chk({tag, ".valid"},      {31'h0, is_req_valid_to_idu}, 32'h0);
      chk({tag, ".araddr"},     araddr,                       RST_PC);
      chk({tag, ".pc"},         pc,                           RST_PC);
      chk({tag, ".inst"},       inst,                         32'h0);
      chk({tag, ".inst_fault"}, {31'h0, inst_fault},          32'h0);
      chk({tag, ".fetch_cnt"},  fetch_cnt,                    32'h0);
   endtask

   // Entry: current negedge is the S_REQ cycle. Exit: next S_REQ cycle.
   task automatic run_vec(input int idx, input vec_t v);
      string t;
      t = $sformatf("v%0d", idx);
      if (v.exp_bus) begin
         chk({t, ".arvalid"}, {31'h0, arvalid}, 32'h1);
         chk({t, ".araddr"},  araddr,           v.exp_pc);
         for (int i = 0; i < v.ar_stall; i++) begin
            step();
            chk({t, ".arvalid_hold"}, {31'h0, arvalid}, 32'h1);
            chk({t, ".araddr_hold"},  araddr,           v.exp_pc);
         end
         arready = 1'b1;
         step();
         arready = 1'b0;
         chk({t, ".rready"},     {31'h0, rready},  32'h1);
         chk({t, ".arvalid_lo"}, {31'h0, arvalid}, 32'h0);
         if (v.wb_in_resp) begin
            wb_valid   = 1'b1;
            wb_next_pc = 32'h1111_1110;
            step();
            wb_valid   = 1'b0;
            chk({t, ".rready_after_wb"}, {31'h0, rready}, 32'h1);
            chk({t, ".pc_after_wb"},     pc,              v.exp_pc);
         end
         rvalid = 1'b1;
         rdata  = v.rdata;
         rresp  = v.rresp;
         step();
         rvalid = 1'b0;
         rdata  = 32'h0;
         rresp  = 2'b00;
      end else begin
         chk({t, ".no_arvalid"}, {31'h0, arvalid}, 32'h0);
         step();
      end
      chk({t, ".valid"}, {31'h0, is_req_valid_to_idu}, 32'h1);
      chk({t, ".inst"},  inst,                         v.exp_inst);
      chk({t, ".pc"},    pc,                           v.exp_pc);
      chk({t, ".fault"}, {31'h0, inst_fault},          {31'h0, v.exp_fault});
      for (int i = 0; i < v.ack_delay; i++) begin
         step();
         chk({t, ".valid_hold"}, {31'h0, is_req_valid_to_idu}, 32'h1);
         chk({t, ".inst_hold"},  inst,                         v.exp_inst);
         chk({t, ".pc_hold"},    pc,                           v.exp_pc);
      end
      is_req_ready_from_idu = 1'b1;
      step();
      is_req_ready_from_idu = 1'b0;
      exp_cnt = exp_cnt + 32'd1;
      chk({t, ".wait_valid"},  {31'h0, is_req_valid_to_idu}, 32'h0);
      chk({t, ".wait_arvld"},  {31'h0, arvalid},             32'h0);
      chk({t, ".fetch_cnt"},   fetch_cnt,                    exp_cnt);
      wb_valid   = 1'b1;
      wb_next_pc = v.next_pc;
      step();
      wb_valid   = 1'b0;
      wb_next_pc = 32'h0;
   endtask

   initial begin
      n_cmp   = 0;
      n_fail  = 0;
      exp_cnt = 32'h0;
      rst = 1'b1;
      arready = 1'b0;
      rdata = 32'h0;
      rresp = 2'b00;
      rvalid = 1'b0;
      is_req_ready_from_idu = 1'b0;
      wb_valid = 1'b0;
      wb_next_pc = 32'h0;

      //          exp_pc        bus  stall wbR  rdata         rresp  ack exp_inst      flt  next_pc
      vecs[0] = '{32'h8000_0000, 1'b1, 0, 1'b0, 32'h0000_0413, 2'b00, 0, 32'h0000_0413, 1'b0, 32'h8000_0010};
      vecs[1] = '{32'h8000_0010, 1'b1, 3, 1'b0, 32'h00a0_0093, 2'b00, 4, 32'h00a0_0093, 1'b0, 32'h8000_0006};
      vecs[2] = '{32'h8000_0006, 1'b0, 0, 1'b0, 32'h0,         2'b00, 1, 32'h0,         1'b1, 32'h8000_0014};
      vecs[3] = '{32'h8000_0014, 1'b1, 1, 1'b0, 32'hdead_beef, 2'b10, 0, 32'hdead_beef, 1'b1, 32'h8000_0018};
      vecs[4] = '{32'h8000_0018, 1'b1, 0, 1'b1, 32'h1234_5678, 2'b00, 2, 32'h1234_5678, 1'b0, 32'h8000_0020};

      step(); step(); step();
      chk_reset_outputs("reset");
      rst = 1'b0;
      step();

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
      chk("after_table.araddr", araddr, 32'h8000_0020);

      // Reset while waiting for R; the beat arriving with reset is dropped.
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("rst_resp.rready", {31'h0, rready}, 32'h1);
      rst    = 1'b1;
      rvalid = 1'b1;
      rdata  = 32'hffff_ffff;
      rresp  = 2'b11;
      step();
      rvalid = 1'b0;
      rdata  = 32'h0;
      rresp  = 2'b00;
      chk_reset_outputs("rst_resp");
      rst = 1'b0;
      step();
      exp_cnt = 32'h0;
      run_vec(5, vecs[0]);

      // Reset while presenting to decode.
      arready = 1'b1;
      step();
      arready = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'h0000_0013;
      step();
      rvalid = 1'b0;
      rdata  = 32'h0;
      chk("rst_valid.valid", {31'h0, is_req_valid_to_idu}, 32'h1);
      chk("rst_valid.pc",    pc,                           32'h8000_0010);
      rst = 1'b1;
      step();
      chk_reset_outputs("rst_valid");
      rst = 1'b0;
      step();
      exp_cnt = 32'h0;
      run_vec(6, vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
